// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped countdown timer feeding one CP0 HWInt line.
// Three word registers (CTRL, PRESET, COUNT) on a 2-bit word address.
// The timer raises irq when the preset count expires. Mode 01 reloads the
// count automatically; modes 00, 10 and 11 are one-shot.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped; COUNT holds; waits for CTRL.EN
// LOAD   | COUNT <= PRESET
// CNT    | counting down; expiry sets irq_flag
// INT    | one cycle after expiry; one-shot clears EN, auto-reload reloads
module timer_irq_source #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  logic [1:0]       state;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;

  logic ctrl_wr;
  logic preset_wr;
  logic en;
  logic reload_mode;
  logic expire;

  assign ctrl_wr     = we && (addr == ADDR_CTRL);
  assign preset_wr   = we && (addr == ADDR_PRESET);
  assign en          = ctrl[0];
  // Only mode 01 reloads; the reserved modes fall back to one-shot.
  assign reload_mode = (ctrl[2:1] == 2'b01);
  // A count of 0 (PRESET=0) expires the same way as a count of 1.
  assign expire      = (state == ST_CNT) && en && (count <= CNT_W'(1));

  // CTRL register: a software write always beats the hardware EN clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= 4'b0;
    end else if (ctrl_wr) begin
      ctrl <= din[3:0];
    end else if ((state == ST_INT) && !reload_mode) begin
      ctrl[0] <= 1'b0;
    end
  end

  // PRESET register; a new value is only picked up at the next LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset <= '0;
    end else if (preset_wr) begin
      preset <= din[CNT_W-1:0];
    end
  end

  // Interrupt flag: a CTRL write clears it, even when expiry happens in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_flag <= 1'b0;
    end else if (ctrl_wr) begin
      irq_flag <= 1'b0;
    end else if (expire) begin
      irq_flag <= 1'b1;
    end else if ((state == ST_INT) && reload_mode) begin
      irq_flag <= 1'b0;
    end
  end

  // Sequencer and down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            count <= '0;
            state <= ST_INT;
          end
        end
        default: begin
          state <= reload_mode ? ST_LOAD : ST_IDLE;
        end
      endcase
    end
  end

  // Read mux; reads have no side effects.
  always_comb begin
    dout = 32'b0;
    case (addr)
      ADDR_CTRL:   dout = {28'b0, ctrl};
      ADDR_PRESET: dout = 32'(preset);
      ADDR_COUNT:  dout = 32'(count);
      default:     dout = 32'b0;
    endcase
  end

  assign irq = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source. Expected register and irq values are queued
// before each clock and compared once the DUT has taken that edge.
module tb_timer_irq_source;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we   = 1'b0;
  logic [31:0] din  = 32'd0;
  logic [31:0] dout;
  logic        irq;

  timer_irq_source #(.CNT_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  localparam int SEL_CTRL   = 0;
  localparam int SEL_PRESET = 1;
  localparam int SEL_COUNT  = 2;
  localparam int SEL_RSVD   = 3;
  localparam int SEL_IRQ    = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Edges E1..E8 after enabling one-shot with PRESET=5
  int os_cnt[8] = '{0, 5, 4, 3, 2, 1, 0, 0};
  int os_irq[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
  // Edges E1..E12 in auto-reload with PRESET=3
  int ar_cnt[12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
  int ar_irq[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  // Edges E1..E5 masked with PRESET=2 (COUNT was left at 2 beforehand)
  int mk_cnt[5] = '{2, 2, 1, 0, 0};
  // Edges E1..E5 with PRESET=7 before the PRESET edit
  int mc_cnt[5] = '{0, 7, 6, 5, 4};
  // Edges F1..F5 after re-enabling with PRESET=10
  int rl_cnt[5] = '{0, 10, 9, 8, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic push_ci(input string tag, input int cnt, input int irqv);
    push_exp({tag, "_count"}, SEL_COUNT, 32'(cnt));
    push_exp({tag, "_irq"}, SEL_IRQ, 32'(irqv));
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == SEL_IRQ) begin
        #1;
        obs = {31'b0, irq};
      end else begin
        addr = 2'(e.sel);
        #1;
        obs = dout;
      end
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    drain();
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    push_exp("rst_ctrl", SEL_CTRL, 32'h0);
    push_exp("rst_preset", SEL_PRESET, 32'h0);
    push_exp("rst_count", SEL_COUNT, 32'h0);
    push_exp("rst_rsvd", SEL_RSVD, 32'h0);
    push_exp("rst_irq", SEL_IRQ, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    push_ci("os_e0", 0, 0);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 8; k++) begin
      push_ci($sformatf("os_e%0d", k + 1), os_cnt[k], os_irq[k]);
      cyc();
    end
    push_exp("os_ctrl_en_clr", SEL_CTRL, 32'h8);
    push_exp("os_irq_held", SEL_IRQ, 32'h1);
    cyc();
    push_exp("os_irq_ack", SEL_IRQ, 32'h0);
    push_exp("os_ctrl_ack", SEL_CTRL, 32'h8);
    wr(2'd0, 32'h8);

    // Auto-reload, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 0; k < 12; k++) begin
      push_ci($sformatf("ar_e%0d", k + 1), ar_cnt[k], ar_irq[k]);
      cyc();
    end
    push_ci("ar_stop", 2, 0);
    wr(2'd0, 32'h0);
    push_ci("ar_hold", 2, 0);
    cyc();

    // Masked: flag sets but irq stays low
    wr(2'd1, 32'd2);
    push_ci("mk_e0", 2, 0);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      push_ci($sformatf("mk_e%0d", k + 1), mk_cnt[k], 0);
      cyc();
    end
    push_exp("mk_ctrl_en_clr", SEL_CTRL, 32'h0);
    push_exp("mk_irq_idle", SEL_IRQ, 32'h0);
    cyc();
    push_exp("mk_irq_after_im", SEL_IRQ, 32'h0);
    push_exp("mk_ctrl_im", SEL_CTRL, 32'h8);
    wr(2'd0, 32'h8);

    // PRESET edited mid-count
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) begin
      push_ci($sformatf("mc_e%0d", k + 1), mc_cnt[k], 0);
      cyc();
    end
    push_ci("mc_e6", 3, 0);
    push_exp("mc_preset_new", SEL_PRESET, 32'd10);
    wr(2'd1, 32'd10);
    push_ci("mc_e7", 2, 0);
    cyc();
    push_ci("mc_e8", 1, 0);
    cyc();
    push_ci("mc_e9", 0, 1);
    cyc();
    push_exp("mc_ctrl_e10", SEL_CTRL, 32'h8);
    push_exp("mc_irq_e10", SEL_IRQ, 32'h1);
    cyc();

    // Disable at COUNT=6, then re-enable reloads PRESET
    push_exp("dis_irq_clr", SEL_IRQ, 32'h0);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) begin
      push_exp($sformatf("dis_f%0d_count", k + 1), SEL_COUNT, 32'(rl_cnt[k]));
      cyc();
    end
    push_exp("dis_f6_count", SEL_COUNT, 32'd6);
    wr(2'd0, 32'h0);
    push_exp("dis_hold1", SEL_COUNT, 32'd6);
    cyc();
    push_exp("dis_hold2", SEL_COUNT, 32'd6);
    cyc();
    push_exp("re_g0", SEL_COUNT, 32'd6);
    wr(2'd0, 32'h9);
    push_exp("re_g1", SEL_COUNT, 32'd6);
    cyc();
    push_exp("re_reload", SEL_COUNT, 32'd10);
    cyc();
    push_exp("re_g3", SEL_COUNT, 32'd9);
    wr(2'd0, 32'h0);
    push_exp("re_g4", SEL_COUNT, 32'd9);
    cyc();

    // Bus corners
    push_exp("bus_count_ro", SEL_COUNT, 32'd9);
    wr(2'd2, 32'h1234);
    push_exp("bus_rsvd_rd", SEL_RSVD, 32'h0);
    push_exp("bus_rsvd_ctrl", SEL_CTRL, 32'h0);
    push_exp("bus_rsvd_preset", SEL_PRESET, 32'd10);
    wr(2'd3, 32'hFFFF_FFFF);

    // PRESET=0 one-shot behaves like PRESET=1
    wr(2'd1, 32'd0);
    push_exp("p0_h0", SEL_COUNT, 32'd9);
    wr(2'd0, 32'h9);
    push_ci("p0_h1", 9, 0);
    cyc();
    push_ci("p0_h2", 0, 0);
    cyc();
    push_ci("p0_h3", 0, 1);
    cyc();
    push_exp("p0_ctrl_h4", SEL_CTRL, 32'h8);
    push_exp("p0_irq_h4", SEL_IRQ, 32'h1);
    cyc();

    // Asynchronous reset with irq high
    rst = 1'b0;
    #1;
    push_exp("arst_irq", SEL_IRQ, 32'h0);
    push_exp("arst_ctrl", SEL_CTRL, 32'h0);
    push_exp("arst_preset", SEL_PRESET, 32'h0);
    push_exp("arst_count", SEL_COUNT, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    // CTRL write on the expiry edge wins over the irq_flag set
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    push_exp("sim_j1", SEL_COUNT, 32'd0);
    cyc();
    push_exp("sim_j2", SEL_COUNT, 32'd2);
    cyc();
    push_exp("sim_j3", SEL_COUNT, 32'd1);
    cyc();
    push_ci("sim_j4", 0, 0);
    wr(2'd0, 32'h9);
    push_exp("sim_j5_ctrl", SEL_CTRL, 32'h8);
    push_exp("sim_j5_irq", SEL_IRQ, 32'h0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
